muldiv_ctrl: RTL and testbench

Sequencer between the CPU control unit and the multi-cycle multiplier and divider datapaths. Accepts MULT/DIV/MFHI/MFLO operations and latches the operands. Pulses the unit's start line and stalls the pipeline while the unit runs. Captures the result into architectural HI/LO registers and serves HI/LO reads back to the register-file write path.

---
 rtl/muldiv_ctrl_if.sv | 13 +
 rtl/muldiv_ctrl.sv | 170 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// CPU-side request bus of the multiply/divide sequencer: operation request,
// operands, pipeline stall and the MFHI/MFLO read-back value.
interface muldiv_ctrl_if;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        stall;
  logic [31:0] rd_data;

  modport master (output op_valid, op_code, rs_val, rt_val, input stall, rd_data);
  modport slave  (input op_valid, op_code, rs_val, rt_val, output stall, rd_data);
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer between the CPU control unit and the multi-cycle mult/div units,
// owning architectural HI/LO. Define MULDIV_MTHILO_EN to enable MTHI/MTLO.
module muldiv_ctrl #(
  parameter int TIMEOUT_CYCLES = 48,
  parameter int CNT_W          = 6
) (
  input  logic               clk,
  input  logic               reset,
  muldiv_ctrl_if.slave       cpu,
  output logic [31:0]        hi,
  output logic [31:0]        lo,
  output logic [31:0]        unit_a,
  output logic [31:0]        unit_b,
  output logic               mult_start,
  input  logic               mult_done,
  input  logic [31:0]        mult_hi,
  input  logic [31:0]        mult_lo,
  output logic               div_start,
  input  logic               div_done,
  input  logic [31:0]        div_rem,
  input  logic [31:0]        div_quo,
  output logic               div_zero,
  output logic               timeout_err
);

  localparam logic [2:0] OP_MULT = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_MFHI = 3'b010;
  localparam logic [2:0] OP_MFLO = 3'b011;
`ifdef MULDIV_MTHILO_EN
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START_M = 3'd1,
    S_START_D = 3'd2,
    S_WAIT_M  = 3'd3,
    S_WAIT_D  = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [31:0]       hi_s, lo_s, unit_a_s, unit_b_s, rd_data_s;
  logic              mult_start_s, div_start_s, div_zero_s, timeout_s, stall_s;

  assign cpu.stall   = stall_s;
  assign cpu.rd_data = rd_data_s;

  // Next-state, datapath updates, stall and read-back decode.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    hi_s         = hi;
    lo_s         = lo;
    unit_a_s     = unit_a;
    unit_b_s     = unit_b;
    mult_start_s = 1'b0;
    div_start_s  = 1'b0;
    div_zero_s   = 1'b0;
    timeout_s    = 1'b0;
    stall_s      = 1'b0;
    rd_data_s    = 32'h0000_0000;
    case (state_r)
      S_IDLE: begin
        if (cpu.op_valid) begin
          case (cpu.op_code)
            OP_MULT: begin
              unit_a_s     = cpu.rs_val;
              unit_b_s     = cpu.rt_val;
              mult_start_s = 1'b1;
              stall_s      = 1'b1;
              state_s      = S_START_M;
            end
            OP_DIV: begin
              if (cpu.rt_val == 32'h0000_0000) begin
                div_zero_s = 1'b1;
              end else begin
                unit_a_s    = cpu.rs_val;
                unit_b_s    = cpu.rt_val;
                div_start_s = 1'b1;
                stall_s     = 1'b1;
                state_s     = S_START_D;
              end
            end
            OP_MFHI: rd_data_s = hi;
            OP_MFLO: rd_data_s = lo;
`ifdef MULDIV_MTHILO_EN
            OP_MTHI: hi_s = cpu.rs_val;
            OP_MTLO: lo_s = cpu.rs_val;
`endif
            default: state_s = S_IDLE;
          endcase
        end else begin
          state_s = S_IDLE;
        end
      end
      // Start pulse is registered, so it was raised on entry and is high here.
      S_START_M: begin
        stall_s = 1'b1;
        cnt_s   = {CNT_W{1'b0}};
        state_s = S_WAIT_M;
      end
      S_START_D: begin
        stall_s = 1'b1;
        cnt_s   = {CNT_W{1'b0}};
        state_s = S_WAIT_D;
      end
      S_WAIT_M: begin
        if (mult_done) begin
          hi_s    = mult_hi;
          lo_s    = mult_lo;
          state_s = S_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          stall_s   = 1'b1;
          timeout_s = 1'b1;
          state_s   = S_IDLE;
        end else begin
          stall_s = 1'b1;
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      S_WAIT_D: begin
        if (div_done) begin
          hi_s    = div_rem;
          lo_s    = div_quo;
          state_s = S_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          stall_s   = 1'b1;
          timeout_s = 1'b1;
          state_s   = S_IDLE;
        end else begin
          stall_s = 1'b1;
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State, counter, HI/LO, operand latches and registered pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      hi          <= 32'h0000_0000;
      lo          <= 32'h0000_0000;
      unit_a      <= 32'h0000_0000;
      unit_b      <= 32'h0000_0000;
      mult_start  <= 1'b0;
      div_start   <= 1'b0;
      div_zero    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      hi          <= hi_s;
      lo          <= lo_s;
      unit_a      <= unit_a_s;
      unit_b      <= unit_b_s;
      mult_start  <= mult_start_s;
      div_start   <= div_start_s;
      div_zero    <= div_zero_s;
      timeout_err <= timeout_s;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with behavioural 34-cycle mult/div unit models.
module tb_muldiv_ctrl;

  localparam int UNIT_LAT = 34;
  localparam int EV_HILO = 0, EV_RD = 1, EV_DZ = 2, EV_TO = 3;
  localparam logic [2:0] OP_MULT = 3'b000, OP_DIV = 3'b001, OP_MFHI = 3'b010;
  localparam logic [2:0] OP_MFLO = 3'b011, OP_MTHI = 3'b100, OP_RSV = 3'b111;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] hi, lo, unit_a, unit_b;
  logic        mult_start, mult_done, div_start, div_done, div_zero, timeout_err;
  logic [31:0] mult_hi, mult_lo, div_rem, div_quo;

  muldiv_ctrl_if bus ();

  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .cpu(bus),
    .hi(hi), .lo(lo), .unit_a(unit_a), .unit_b(unit_b),
    .mult_start(mult_start), .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_start(div_start), .div_done(div_done), .div_rem(div_rem), .div_quo(div_quo),
    .div_zero(div_zero), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int   n_checks = 0, n_pass = 0;
  int   ms_cnt = 0, ds_cnt = 0, to_cnt = 0;
  exp_t sb[$];

  // Unit models: done rises UNIT_LAT edges after the edge that samples start.
  logic        m_hang = 1'b0, force_done = 1'b0;
  int          m_cnt, d_cnt;
  logic        m_done_r, d_done_r;
  logic [63:0] m_prod;
  logic [31:0] d_q, d_r;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt <= 0; m_done_r <= 1'b0; m_prod <= 64'h0;
      d_cnt <= 0; d_done_r <= 1'b0; d_q <= 32'h0; d_r <= 32'h0;
    end else begin
      m_done_r <= 1'b0;
      d_done_r <= 1'b0;
      if (mult_start) begin
        m_cnt  <= UNIT_LAT;
        m_prod <= $signed({{32{unit_a[31]}}, unit_a}) * $signed({{32{unit_b[31]}}, unit_b});
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1 && !m_hang) m_done_r <= 1'b1;
      end
      if (div_start) begin
        d_cnt <= UNIT_LAT;
        d_q   <= (unit_b == 32'h0) ? 32'h0 : unit_a / unit_b;
        d_r   <= (unit_b == 32'h0) ? 32'h0 : unit_a % unit_b;
      end else if (d_cnt != 0) begin
        d_cnt <= d_cnt - 1;
        if (d_cnt == 1) d_done_r <= 1'b1;
      end
    end
  end

  assign mult_done = m_done_r | force_done;
  assign mult_hi   = force_done ? 32'hA5A5_A5A5 : m_prod[63:32];
  assign mult_lo   = force_done ? 32'h5A5A_5A5A : m_prod[31:0];
  assign div_done  = d_done_r;
  assign div_rem   = d_r;
  assign div_quo   = d_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  task automatic pop_check(input int kind, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL sb_unexpected: event kind %0d (0x%08h,0x%08h) with nothing expected", kind, a, b);
    end else begin
      e = sb.pop_front();
      if (e.kind == kind && e.a === a && e.b === b) n_pass++;
      else $display("FAIL sb_event: got kind %0d (0x%08h,0x%08h), required kind %0d (0x%08h,0x%08h)",
                    kind, a, b, e.kind, e.a, e.b);
    end
  endtask

  // Monitor: turns observable DUT outputs into events checked against the queue.
  logic [31:0] prev_hi = 32'h0, prev_lo = 32'h0;
  always @(negedge clk) begin
    if (reset) begin
      prev_hi = hi;
      prev_lo = lo;
    end else begin
      if (hi !== prev_hi || lo !== prev_lo) pop_check(EV_HILO, hi, lo);
      prev_hi = hi;
      prev_lo = lo;
      if (div_zero) pop_check(EV_DZ, 32'h0, 32'h0);
      if (timeout_err) begin
        to_cnt++;
        pop_check(EV_TO, 32'h0, 32'h0);
      end
      if (bus.op_valid && (bus.op_code == OP_MFHI || bus.op_code == OP_MFLO) && !bus.stall)
        pop_check(EV_RD, bus.rd_data, 32'h0);
      if (mult_start) ms_cnt++;
      if (div_start) ds_cnt++;
    end
  end

  // Presents one request (called just after a rising edge) and counts stalled cycles.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n_stall);
    logic st;
    bit   released;
    n_stall  = 0;
    released = 1'b0;
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.rs_val   = a;
    bus.rt_val   = b;
    for (int i = 0; i < 200 && !released; i++) begin
      @(negedge clk);
      st = bus.stall;
      if (st) n_stall++;
      @(posedge clk);
      #1;
      bus.op_valid = 1'b0;
      if (!st) released = 1'b1;
    end
    if (!released) begin
      n_checks++;
      $display("FAIL stall_release: stall still 1 after 200 cycles, required 0");
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hi"}, hi, 32'h0);
    check({tag, "_lo"}, lo, 32'h0);
    check({tag, "_unit_a"}, unit_a, 32'h0);
    check({tag, "_unit_b"}, unit_b, 32'h0);
    check({tag, "_stall"}, {31'h0, bus.stall}, 32'h0);
    check({tag, "_rd_data"}, bus.rd_data, 32'h0);
    check({tag, "_mult_start"}, {31'h0, mult_start}, 32'h0);
    check({tag, "_div_start"}, {31'h0, div_start}, 32'h0);
    check({tag, "_div_zero"}, {31'h0, div_zero}, 32'h0);
    check({tag, "_timeout_err"}, {31'h0, timeout_err}, 32'h0);
  endtask

  initial begin
    int          ns, ms0, ds0, to0;
    logic [31:0] exp_hi;
    bus.op_valid = 1'b0;
    bus.op_code  = 3'b000;
    bus.rs_val   = 32'h0;
    bus.rt_val   = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 7 * -3 = -21: 36 stalled cycles = accept + start + 34 unit cycles
    ms0 = ms_cnt;
    sb.push_back('{EV_HILO, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    issue(OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD, ns);
    check("mult_stall_cycles", 32'(ns), 32'd36);
    check("mult_start_pulses", 32'(ms_cnt - ms0), 32'd1);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    sb.push_back('{EV_RD, 32'hFFFF_FFEB, 32'h0});
    issue(OP_MFLO, 32'h0, 32'h0, ns);
    check("mflo_stall_cycles", 32'(ns), 32'd0);

    ds0 = ds_cnt;
    sb.push_back('{EV_HILO, 32'd2, 32'd14});
    issue(OP_DIV, 32'd100, 32'd7, ns);
    check("div_stall_cycles", 32'(ns), 32'd36);
    check("div_start_pulses", 32'(ds_cnt - ds0), 32'd1);
    check("div_hi", hi, 32'd2);
    check("div_lo", lo, 32'd14);
    sb.push_back('{EV_RD, 32'd2, 32'h0});
    issue(OP_MFHI, 32'h0, 32'h0, ns);
    check("mfhi_stall_cycles", 32'(ns), 32'd0);

    ds0 = ds_cnt;
    sb.push_back('{EV_DZ, 32'h0, 32'h0});
    issue(OP_DIV, 32'd5, 32'd0, ns);
    repeat (2) @(posedge clk);
    #1;
    check("divzero_stall_cycles", 32'(ns), 32'd0);
    check("divzero_no_start", 32'(ds_cnt - ds0), 32'd0);
    check("divzero_hi_kept", hi, 32'd2);
    check("divzero_lo_kept", lo, 32'd14);

    // Hung multiplier: accept + start + 48 waiting cycles stalled
    m_hang = 1'b1;
    to0 = to_cnt;
    sb.push_back('{EV_TO, 32'h0, 32'h0});
    issue(OP_MULT, 32'd9, 32'd9, ns);
    @(negedge clk);
    check("timeout_stall_cycles", 32'(ns), 32'd50);
    check("timeout_pulses", 32'(to_cnt - to0), 32'd1);
    check("timeout_hi_kept", hi, 32'd2);
    check("timeout_lo_kept", lo, 32'd14);
    check("timeout_stall_low", {31'h0, bus.stall}, 32'h0);

    // Reset in the 10th WAIT_M cycle, then a stray done while idle
    @(posedge clk);
    #1;
    bus.op_valid = 1'b1;
    bus.op_code  = OP_MULT;
    bus.rs_val   = 32'd5;
    bus.rt_val   = 32'd6;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    #1;
    reset  = 1'b0;
    m_hang = 1'b0;
    @(posedge clk);
    #1;
    force_done = 1'b1;
    @(posedge clk);
    #1;
    force_done = 1'b0;
    @(negedge clk);
    check("stray_done_hi", hi, 32'h0);
    check("stray_done_lo", lo, 32'h0);
    @(posedge clk);
    #1;
    sb.push_back('{EV_HILO, 32'h0, 32'd12});
    issue(OP_MULT, 32'd3, 32'd4, ns);
    check("mult2_stall_cycles", 32'(ns), 32'd36);
    check("mult2_hi", hi, 32'h0);
    check("mult2_lo", lo, 32'd12);

`ifdef MULDIV_MTHILO_EN
    exp_hi = 32'hDEAD_BEEF;
    sb.push_back('{EV_HILO, 32'hDEAD_BEEF, 32'd12});
`else
    exp_hi = 32'h0;
`endif
    issue(OP_MTHI, 32'hDEAD_BEEF, 32'h0, ns);
    check("mthi_stall_cycles", 32'(ns), 32'd0);
    check("mthi_hi", hi, exp_hi);
    sb.push_back('{EV_RD, exp_hi, 32'h0});
    issue(OP_MFHI, 32'h0, 32'h0, ns);
    check("mthi_mfhi_stall_cycles", 32'(ns), 32'd0);

    bus.op_valid = 1'b1;
    bus.op_code  = OP_RSV;
    bus.rs_val   = 32'h1234_5678;
    bus.rt_val   = 32'h0;
    @(negedge clk);
    check("reserved_stall", {31'h0, bus.stall}, 32'h0);
    check("reserved_rd_data", bus.rd_data, 32'h0);
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reserved_hi_kept", hi, exp_hi);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
